// File: rtl/add_issue_ctrl.sv
// rtl/add_issue_ctrl.sv - operand issue and result capture control for a pipelined 32-bit adder
module add_issue_ctrl #(
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] a_hold,
    output logic [31:0] b_hold,
    input  logic [31:0] add_sum,
    input  logic        add_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_sum,
    output logic        out_cout,
    output logic        out_zero,
    output logic        out_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter reload: the capture edge is the LATENCY-th edge after accept.
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_a_hold;
    logic [31:0] r_b_hold;
    logic [31:0] r_out_sum;
    logic        r_out_cout;
    logic        r_out_zero;
    logic        r_out_ovf;
    logic        w_in_ready;
    logic        w_accept;
    logic        w_capture;
    logic        w_ovf;

    assign w_accept  = in_valid & w_in_ready;
    assign w_capture = (r_state == WAIT) && (r_cnt == 4'd0);
    // Signed overflow: like-signed operands whose sum flips the sign bit.
    assign w_ovf     = (r_a_hold[31] == r_b_hold[31]) & (add_sum[31] != r_a_hold[31]);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and ready decode; DONE re-accepts in the same edge it hands off.
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_in_ready = out_ready;
                if (out_ready) begin
                    w_next_state = in_valid ? WAIT : IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Operand hold, latency countdown and result capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt      <= 4'd0;
            r_a_hold   <= 32'd0;
            r_b_hold   <= 32'd0;
            r_out_sum  <= 32'd0;
            r_out_cout <= 1'b0;
            r_out_zero <= 1'b0;
            r_out_ovf  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a_hold <= in_a;
                r_b_hold <= in_b;
                r_cnt    <= LAT_M1;
            end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture) begin
                r_out_sum  <= add_sum;
                r_out_cout <= add_cout;
                r_out_zero <= (add_sum == 32'd0);
                r_out_ovf  <= w_ovf;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign a_hold    = r_a_hold;
    assign b_hold    = r_b_hold;
    assign out_valid = (r_state == DONE);
    assign out_sum   = r_out_sum;
    assign out_cout  = r_out_cout;
    assign out_zero  = r_out_zero;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_add_issue_ctrl.sv
// tb/tb_add_issue_ctrl.sv - directed self-checking bench for add_issue_ctrl
module tb_add_issue_ctrl;

    logic        clk;
    logic        reset;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] a_hold;
    logic [31:0] b_hold;
    logic [31:0] add_sum;
    logic        add_cout;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        out_zero;
    logic        out_ovf;

    logic        l1_in_valid;
    logic        l1_in_ready;
    logic [31:0] l1_in_a;
    logic [31:0] l1_in_b;
    logic [31:0] l1_a_hold;
    logic [31:0] l1_b_hold;
    logic [31:0] l1_add_sum;
    logic        l1_add_cout;
    logic        l1_out_valid;
    logic        l1_out_ready;
    logic [31:0] l1_out_sum;
    logic        l1_out_cout;
    logic        l1_out_zero;
    logic        l1_out_ovf;

    int total;
    int bad;

    // Adder stand-in: operands are held stable, so a combinational sum is valid at capture.
    assign {add_cout, add_sum}       = {1'b0, a_hold} + {1'b0, b_hold};
    assign {l1_add_cout, l1_add_sum} = {1'b0, l1_a_hold} + {1'b0, l1_b_hold};

    add_issue_ctrl #(.LATENCY(3)) u3 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .a_hold    (a_hold),
        .b_hold    (b_hold),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf)
    );

    add_issue_ctrl #(.LATENCY(1)) u1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (l1_in_valid),
        .in_ready  (l1_in_ready),
        .in_a      (l1_in_a),
        .in_b      (l1_in_b),
        .a_hold    (l1_a_hold),
        .b_hold    (l1_b_hold),
        .add_sum   (l1_add_sum),
        .add_cout  (l1_add_cout),
        .out_valid (l1_out_valid),
        .out_ready (l1_out_ready),
        .out_sum   (l1_out_sum),
        .out_cout  (l1_out_cout),
        .out_zero  (l1_out_zero),
        .out_ovf   (l1_out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete LATENCY=3 transaction with out_ready held high.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] s, input logic c, input logic z, input logic o);
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        chk({tag, ".a_hold"}, a_hold, a);
        chk({tag, ".b_hold"}, b_hold, b);
        chk({tag, ".rdy_wait"}, 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        step();
        chk({tag, ".vld_k1"}, 32'(out_valid), 32'd0);
        step();
        chk({tag, ".vld_k2"}, 32'(out_valid), 32'd0);
        step();
        chk({tag, ".vld_k3"}, 32'(out_valid), 32'd1);
        chk({tag, ".sum"}, out_sum, s);
        chk({tag, ".cout"}, 32'(out_cout), 32'(c));
        chk({tag, ".zero"}, 32'(out_zero), 32'(z));
        chk({tag, ".ovf"}, 32'(out_ovf), 32'(o));
        chk({tag, ".rdy_done"}, 32'(in_ready), 32'd1);
        step();
        chk({tag, ".vld_k4"}, 32'(out_valid), 32'd0);
        chk({tag, ".rdy_idle"}, 32'(in_ready), 32'd1);
    endtask

    logic [31:0] v_a [4];
    logic [31:0] v_b [4];
    logic [31:0] v_s [4];

    initial begin
        total        = 0;
        bad          = 0;
        reset        = 1'b0;
        in_valid     = 1'b0;
        in_a         = 32'd0;
        in_b         = 32'd0;
        out_ready    = 1'b0;
        l1_in_valid  = 1'b0;
        l1_in_a      = 32'd0;
        l1_in_b      = 32'd0;
        l1_out_ready = 1'b1;

        // Reset state
        #3;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.a_hold", a_hold, 32'd0);
        chk("rst.out_sum", out_sum, 32'd0);
        step();
        step();
        reset = 1'b1;

        // Basic add, first accept on first edge after reset release
        run_op("add5p3", 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
        run_op("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        run_op("posovf", 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        run_op("negovf", 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1);

        // Back-pressure in DONE, ignored in_valid during WAIT, then same-edge hand-off
        in_a      = 32'h0000_0010;
        in_b      = 32'h0000_0020;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        chk("bp.a_hold", a_hold, 32'h0000_0010);
        in_a = 32'h0000_0099;
        step();
        chk("bp.wait_ignore", a_hold, 32'h0000_0010);
        step();
        chk("bp.vld_k2", 32'(out_valid), 32'd0);
        step();
        chk("bp.vld_k3", 32'(out_valid), 32'd1);
        chk("bp.sum", out_sum, 32'h0000_0030);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp.hold_vld", 32'(out_valid), 32'd1);
            chk("bp.hold_sum", out_sum, 32'h0000_0030);
            chk("bp.hold_rdy", 32'(in_ready), 32'd0);
            chk("bp.hold_a", a_hold, 32'h0000_0010);
        end
        in_a      = 32'h0000_0100;
        in_b      = 32'h0000_0001;
        out_ready = 1'b1;
        #1;
        chk("ho.rdy_pre", 32'(in_ready), 32'd1);
        step();
        chk("ho.vld_drop", 32'(out_valid), 32'd0);
        chk("ho.a_hold", a_hold, 32'h0000_0100);
        chk("ho.rdy_wait", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        step();
        step();
        chk("ho.vld_k2", 32'(out_valid), 32'd0);
        step();
        chk("ho.vld_k3", 32'(out_valid), 32'd1);
        chk("ho.sum", out_sum, 32'h0000_0101);
        step();
        chk("ho.idle", 32'(out_valid), 32'd0);

        // Reset mid-WAIT with cnt=1
        in_a     = 32'h0000_0001;
        in_b     = 32'h0000_0002;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        #2;
        reset = 1'b0;
        #1;
        chk("mrst.out_valid", 32'(out_valid), 32'd0);
        chk("mrst.a_hold", a_hold, 32'd0);
        chk("mrst.out_sum", out_sum, 32'd0);
        chk("mrst.in_ready", 32'(in_ready), 32'd1);
        step();
        chk("mrst.held", 32'(out_valid), 32'd0);
        reset = 1'b1;
        run_op("postrst", 32'h0000_0007, 32'h0000_0008, 32'h0000_000F, 1'b0, 1'b0, 1'b0);

        // LATENCY=1 back-to-back stream
        v_a[0] = 32'h0000_0001; v_b[0] = 32'h0000_0002; v_s[0] = 32'h0000_0003;
        v_a[1] = 32'hFFFF_FFFF; v_b[1] = 32'hFFFF_FFFF; v_s[1] = 32'hFFFF_FFFE;
        v_a[2] = 32'h1234_5678; v_b[2] = 32'h1111_1111; v_s[2] = 32'h2345_6789;
        v_a[3] = 32'hA000_0000; v_b[3] = 32'h6000_0000; v_s[3] = 32'h0000_0000;
        l1_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            l1_in_a = v_a[i];
            l1_in_b = v_b[i];
            step();
            chk("l1.vld_acc", 32'(l1_out_valid), 32'd0);
            chk("l1.a_hold", l1_a_hold, v_a[i]);
            step();
            chk("l1.vld_res", 32'(l1_out_valid), 32'd1);
            chk("l1.sum", l1_out_sum, v_s[i]);
            chk("l1.rdy_done", 32'(l1_in_ready), 32'd1);
        end
        l1_in_valid = 1'b0;
        step();
        chk("l1.idle", 32'(l1_out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
